// File: rtl/jelly3_bram_arbiter.sv
// Round-robin arbiter that shares one native BRAM port among NUM requesters.
// Commands are registered onto the port; read data is routed back after RLATENCY+1 cycles.
module jelly3_bram_arbiter #(
  parameter int unsigned NUM       = 4,
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned DATA_BITS = 32,
  parameter int unsigned BYTE_BITS = 8,
  parameter int unsigned WE_BITS   = DATA_BITS / BYTE_BITS,
  parameter int unsigned RLATENCY  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cke,

  input  logic [NUM-1:0]           s_valid,
  output logic [NUM-1:0]           s_ready,
  input  logic [NUM*WE_BITS-1:0]   s_we,
  input  logic [NUM*ADDR_BITS-1:0] s_addr,
  input  logic [NUM*DATA_BITS-1:0] s_wdata,
  output logic [NUM-1:0]           s_rvalid,
  output logic [DATA_BITS-1:0]     s_rdata,

  output logic                     m_en,
  output logic [WE_BITS-1:0]       m_we,
  output logic [ADDR_BITS-1:0]     m_addr,
  output logic [DATA_BITS-1:0]     m_wdata,
  input  logic [DATA_BITS-1:0]     m_rdata
);

  localparam int unsigned IDX_BITS = (NUM > 1) ? $clog2(NUM) : 1;
  localparam int unsigned LAST     = RLATENCY - 1;

  logic [IDX_BITS-1:0]  last_q;
  logic [NUM-1:0]       grant_oh;
  logic                 grant_any;
  logic [IDX_BITS-1:0]  grant_idx;
  int unsigned          cand;

  logic [WE_BITS-1:0]   sel_we;
  logic [ADDR_BITS-1:0] sel_addr;
  logic [DATA_BITS-1:0] sel_wdata;
  logic                 xfer;
  logic                 xfer_read;

  logic                 m_en_q;
  logic [WE_BITS-1:0]   m_we_q;
  logic [ADDR_BITS-1:0] m_addr_q;
  logic [DATA_BITS-1:0] m_wdata_q;

  // Command stage travels with m_en; the pipe below covers the BRAM read latency.
  logic                 cmd_rd_q;
  logic [IDX_BITS-1:0]  cmd_idx_q;
  logic [RLATENCY-1:0]  pipe_rd_q;
  logic [IDX_BITS-1:0]  pipe_idx_q [RLATENCY];

  // Search starts just after the last winner and wraps; first valid requester wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    grant_oh  = '0;
    cand      = 0;
    for (int unsigned k = 0; k < NUM; k++) begin
      cand = (32'(last_q) + 32'd1 + k) % NUM;
      if (!grant_any && s_valid[cand]) begin
        grant_any      = 1'b1;
        grant_idx      = IDX_BITS'(cand);
        grant_oh[cand] = 1'b1;
      end
    end
  end

  always_comb begin
    sel_we    = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NUM; i++) begin
      if (grant_oh[i]) begin
        sel_we    = s_we[i*WE_BITS +: WE_BITS];
        sel_addr  = s_addr[i*ADDR_BITS +: ADDR_BITS];
        sel_wdata = s_wdata[i*DATA_BITS +: DATA_BITS];
      end
    end
  end

  assign s_ready   = cke ? grant_oh : '0;
  assign xfer      = cke & grant_any;
  assign xfer_read = xfer & (sel_we == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q    <= IDX_BITS'(NUM - 1);
      m_en_q    <= 1'b0;
      m_we_q    <= '0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
    end else if (cke) begin
      if (xfer) begin
        last_q    <= grant_idx;
        m_en_q    <= 1'b1;
        m_we_q    <= sel_we;
        m_addr_q  <= sel_addr;
        m_wdata_q <= sel_wdata;
      end else begin
        m_en_q    <= 1'b0;
        m_we_q    <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_rd_q  <= 1'b0;
      cmd_idx_q <= '0;
      pipe_rd_q <= '0;
      for (int unsigned i = 0; i < RLATENCY; i++) begin
        pipe_idx_q[i] <= '0;
      end
    end else if (cke) begin
      cmd_rd_q      <= xfer_read;
      cmd_idx_q     <= grant_idx;
      pipe_rd_q[0]  <= cmd_rd_q;
      pipe_idx_q[0] <= cmd_idx_q;
      for (int unsigned i = 1; i < RLATENCY; i++) begin
        pipe_rd_q[i]  <= pipe_rd_q[i-1];
        pipe_idx_q[i] <= pipe_idx_q[i-1];
      end
    end
  end

  always_comb begin
    s_rvalid = '0;
    if (cke && pipe_rd_q[LAST]) begin
      s_rvalid[pipe_idx_q[LAST]] = 1'b1;
    end
  end

  assign s_rdata = m_rdata;
  assign m_en    = m_en_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;

endmodule

// File: tb/tb_jelly3_bram_arbiter.sv
// Bench for jelly3_bram_arbiter: directed scenarios followed by random traffic,
// checked every cycle against a transaction-level model with a shadow memory.
module tb_jelly3_bram_arbiter;

  localparam int NUM       = 4;
  localparam int ADDR_BITS = 10;
  localparam int DATA_BITS = 32;
  localparam int BYTE_BITS = 8;
  localparam int WE_BITS   = 4;
  localparam int RLATENCY  = 2;
  localparam int DEPTH     = 1024;

  typedef struct {
    logic [WE_BITS-1:0]   we;
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] wdata;
  } cmd_t;

  typedef struct {
    int                   due;
    int                   idx;
    logic [DATA_BITS-1:0] data;
  } resp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     reset;
  logic                     cke;
  logic [NUM-1:0]           s_valid;
  logic [NUM-1:0]           s_ready;
  logic [NUM*WE_BITS-1:0]   s_we;
  logic [NUM*ADDR_BITS-1:0] s_addr;
  logic [NUM*DATA_BITS-1:0] s_wdata;
  logic [NUM-1:0]           s_rvalid;
  logic [DATA_BITS-1:0]     s_rdata;
  logic                     m_en;
  logic [WE_BITS-1:0]       m_we;
  logic [ADDR_BITS-1:0]     m_addr;
  logic [DATA_BITS-1:0]     m_wdata;
  logic [DATA_BITS-1:0]     m_rdata;

  jelly3_bram_arbiter #(
    .NUM       (NUM),
    .ADDR_BITS (ADDR_BITS),
    .DATA_BITS (DATA_BITS),
    .BYTE_BITS (BYTE_BITS),
    .WE_BITS   (WE_BITS),
    .RLATENCY  (RLATENCY)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cke      (cke),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_we     (s_we),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_rvalid (s_rvalid),
    .s_rdata  (s_rdata),
    .m_en     (m_en),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata)
  );

  function automatic logic [DATA_BITS-1:0] init_val(int a);
    if (a == 5) return 32'hDEAD_BEEF;
    if (a == 9) return 32'hAAAA_AAAA;
    return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // BRAM environment: cke-gated, byte-masked writes, RLATENCY-cycle registered read.
  logic                 bram_init;
  logic [DATA_BITS-1:0] mem    [DEPTH];
  logic [DATA_BITS-1:0] bram_p [RLATENCY];
  assign m_rdata = bram_p[RLATENCY-1];

  always @(posedge clk) begin
    if (bram_init) begin
      for (int a = 0; a < DEPTH; a++) mem[a] <= init_val(a);
    end else if (cke) begin
      if (m_en) begin
        for (int b = 0; b < WE_BITS; b++) begin
          if (m_we[b]) mem[m_addr][b*8 +: 8] <= m_wdata[b*8 +: 8];
        end
        bram_p[0] <= mem[m_addr];
      end
      for (int s = 1; s < RLATENCY; s++) bram_p[s] <= bram_p[s-1];
    end
  end

  // Reference model state
  logic [DATA_BITS-1:0] shadow [DEPTH];
  cmd_t                 cmdq [NUM][$];
  resp_t                respq[$];
  int                   last_m;
  int                   cke_cnt;
  logic                 exp_m_en;
  logic [WE_BITS-1:0]   exp_m_we;
  logic [ADDR_BITS-1:0] exp_m_addr;
  logic [DATA_BITS-1:0] exp_m_wdata;

  logic [NUM-1:0]       gate;
  bit                   mutate_en;
  int                   rv_cnt [NUM];

  logic [NUM-1:0]       obs_ready;
  logic [NUM-1:0]       obs_rvalid;
  logic [DATA_BITS-1:0] obs_rdata;
  logic                 obs_m_en;
  logic [ADDR_BITS-1:0] obs_m_addr;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NUM-1:0] v, input int last);
    for (int k = 1; k <= NUM; k++) begin
      if (v[(last + k) % NUM]) return (last + k) % NUM;
    end
    return -1;
  endfunction

  function automatic int oh2idx(input logic [NUM-1:0] v);
    if ($countones(v) != 1) return -1;
    for (int i = 0; i < NUM; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.we    = ($urandom_range(1) == 0) ? 4'b0000 : 4'($urandom);
    c.addr  = 10'($urandom_range(31));
    c.wdata = $urandom;
    return c;
  endfunction

  task automatic model_reset();
    last_m      = NUM - 1;
    respq.delete();
    exp_m_en    = 1'b0;
    exp_m_we    = '0;
    exp_m_addr  = '0;
    exp_m_wdata = '0;
  endtask

  task automatic drive();
    for (int i = 0; i < NUM; i++) begin
      if (mutate_en && cmdq[i].size() > 0 && $urandom_range(9) == 0) cmdq[i][0] = rand_cmd();
      if (gate[i] && cmdq[i].size() > 0) begin
        s_valid[i]                   = 1'b1;
        s_we[i*WE_BITS +: WE_BITS]   = cmdq[i][0].we;
        s_addr[i*ADDR_BITS +: ADDR_BITS] = cmdq[i][0].addr;
        s_wdata[i*DATA_BITS +: DATA_BITS] = cmdq[i][0].wdata;
      end else begin
        s_valid[i]                   = 1'b0;
        s_we[i*WE_BITS +: WE_BITS]   = 4'($urandom);
        s_addr[i*ADDR_BITS +: ADDR_BITS] = 10'($urandom);
        s_wdata[i*DATA_BITS +: DATA_BITS] = $urandom;
      end
    end
  endtask

  // One clock cycle: drive, check outputs at negedge, advance model at posedge.
  task automatic tick();
    int                   g;
    logic [NUM-1:0]       exp_ready;
    logic [NUM-1:0]       exp_rv;
    logic [WE_BITS-1:0]   we;
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] wdata;
    resp_t                r;
    drive();
    @(negedge clk);
    obs_ready  = s_ready;
    obs_rvalid = s_rvalid;
    obs_rdata  = s_rdata;
    obs_m_en   = m_en;
    obs_m_addr = m_addr;
    g = -1;
    if (!reset) begin
      if (cke) g = rr_pick(s_valid, last_m);
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      chk("s_ready", obs_ready, exp_ready);
      exp_rv = '0;
      if (cke && respq.size() > 0 && respq[0].due == cke_cnt) begin
        exp_rv[respq[0].idx] = 1'b1;
        chk("s_rdata", obs_rdata, respq[0].data);
        void'(respq.pop_front());
      end
      chk("s_rvalid", obs_rvalid, exp_rv);
      chk("m_en", m_en, exp_m_en);
      chk("m_we", m_we, exp_m_we);
      chk("m_addr", m_addr, exp_m_addr);
      chk("m_wdata", m_wdata, exp_m_wdata);
      for (int i = 0; i < NUM; i++) rv_cnt[i] += int'(obs_rvalid[i]);
    end
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else if (cke) begin
      if (g >= 0) begin
        we    = s_we[g*WE_BITS +: WE_BITS];
        addr  = s_addr[g*ADDR_BITS +: ADDR_BITS];
        wdata = s_wdata[g*DATA_BITS +: DATA_BITS];
        exp_m_en    = 1'b1;
        exp_m_we    = we;
        exp_m_addr  = addr;
        exp_m_wdata = wdata;
        last_m      = g;
        if (we == '0) begin
          r.due  = cke_cnt + RLATENCY + 1;
          r.idx  = g;
          r.data = shadow[addr];
          respq.push_back(r);
        end else begin
          for (int b = 0; b < WE_BITS; b++) begin
            if (we[b]) shadow[addr][b*8 +: 8] = wdata[b*8 +: 8];
          end
        end
        void'(cmdq[g].pop_front());
      end else begin
        exp_m_en = 1'b0;
        exp_m_we = '0;
      end
      cke_cnt++;
    end
    #1;
  endtask

  function automatic cmd_t mk(input logic [3:0] we, input int addr, input logic [31:0] wdata);
    cmd_t c;
    c.we    = we;
    c.addr  = 10'(addr);
    c.wdata = wdata;
    return c;
  endfunction

  function automatic bit pending();
    for (int i = 0; i < NUM; i++) if (cmdq[i].size() > 0) return 1'b1;
    return respq.size() > 0;
  endfunction

  initial begin
    int  idx;
    bit  got;
    int  n;
    for (int a = 0; a < DEPTH; a++) shadow[a] = init_val(a);
    reset     = 1'b1;
    cke       = 1'b1;
    gate      = '1;
    mutate_en = 1'b0;
    bram_init = 1'b1;
    cke_cnt   = 0;
    s_valid   = '0;
    s_we      = '0;
    s_addr    = '0;
    s_wdata   = '0;
    model_reset();
    tick();
    bram_init = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Single read by requester 2
    cmdq[2].push_back(mk(4'b0000, 5, 32'h0));
    tick();
    chk("single.ready", obs_ready, 4'b0100);
    tick();
    chk("single.m_en", obs_m_en, 1'b1);
    chk("single.m_addr", obs_m_addr, 10'd5);
    tick();
    chk("single.early_rvalid", obs_rvalid, 4'b0000);
    tick();
    chk("single.rvalid", obs_rvalid, 4'b0100);
    chk("single.rdata", obs_rdata, 32'hDEAD_BEEF);

    // Contention from reset release
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      rv_cnt[i] = 0;
      for (int k = 0; k < 3; k++) cmdq[i].push_back(mk(4'b0000, 16 + 4 * i + k, 32'h0));
    end
    for (int k = 0; k < 12; k++) begin
      tick();
      idx = oh2idx(obs_ready);
      chk("contention.grant", 64'(idx), 64'(k % NUM));
    end
    for (int k = 0; k < 4; k++) tick();
    for (int i = 0; i < NUM; i++) chk("contention.rvalid_count", 64'(rv_cnt[i]), 64'd3);

    // Partial write followed by read of the same address
    cmdq[1].push_back(mk(4'b0011, 9, 32'h1234_5678));
    tick();
    chk("raw.write_ready", obs_ready, 4'b0010);
    cmdq[3].push_back(mk(4'b0000, 9, 32'h0));
    tick();
    chk("raw.read_ready", obs_ready, 4'b1000);
    tick();
    tick();
    chk("raw.no_write_rvalid", obs_rvalid, 4'b0000);
    tick();
    chk("raw.rvalid", obs_rvalid, 4'b1000);
    chk("raw.rdata", obs_rdata, 32'hAAAA_5678);

    // Clock-enable stall of three cycles
    cmdq[0].push_back(mk(4'b0000, 5, 32'h0));
    tick();
    chk("stall.ready", obs_ready, 4'b0001);
    cke = 1'b0;
    cmdq[1].push_back(mk(4'b0000, 9, 32'h0));
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall.no_ready", obs_ready, 4'b0000);
      chk("stall.m_en_hold", obs_m_en, 1'b1);
      chk("stall.m_addr_hold", obs_m_addr, 10'd5);
    end
    cke = 1'b1;
    tick();
    chk("stall.resume_ready", obs_ready, 4'b0010);
    tick();
    chk("stall.not_yet", obs_rvalid, 4'b0000);
    tick();
    chk("stall.rvalid", obs_rvalid, 4'b0001);
    chk("stall.rdata", obs_rdata, 32'hDEAD_BEEF);
    for (int k = 0; k < 3; k++) tick();

    // Reset with two reads in flight
    cmdq[0].push_back(mk(4'b0000, 1, 32'h0));
    cmdq[1].push_back(mk(4'b0000, 2, 32'h0));
    tick();
    chk("rst.first", obs_ready, 4'b0001);
    tick();
    chk("rst.second", obs_ready, 4'b0010);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rst.dropped", obs_rvalid, 4'b0000);
    end
    cmdq[0].push_back(mk(4'b0000, 3, 32'h0));
    cmdq[3].push_back(mk(4'b0000, 4, 32'h0));
    tick();
    chk("rst.prio0", obs_ready, 4'b0001);
    for (int k = 0; k < 5; k++) tick();

    // Fairness against a continuously valid requester 0
    for (int k = 0; k < 6; k++) cmdq[0].push_back(mk(4'b0000, k, 32'h0));
    tick();
    chk("fair.req0", obs_ready, 4'b0001);
    cmdq[2].push_back(mk(4'b0000, 7, 32'h0));
    got = 1'b0;
    for (int k = 0; k < 2 && !got; k++) begin
      tick();
      got = (obs_ready == 4'b0100);
    end
    chk("fair.req2_within2", got, 1'b1);
    tick();
    chk("fair.req0_resume", obs_ready, 4'b0001);
    n = 0;
    while (pending() && n < 50) begin
      tick();
      n++;
    end
    chk("fair.drained", pending(), 1'b0);

    // Random traffic
    mutate_en = 1'b1;
    for (int c = 0; c < 400; c++) begin
      cke = ($urandom_range(9) != 0);
      for (int i = 0; i < NUM; i++) begin
        gate[i] = ($urandom_range(3) != 0);
        if (cmdq[i].size() < 2 && $urandom_range(1) == 1) cmdq[i].push_back(rand_cmd());
      end
      tick();
    end
    mutate_en = 1'b0;
    gate      = '1;
    cke       = 1'b1;
    n = 0;
    while (pending() && n < 300) begin
      tick();
      n++;
    end
    chk("random.drained", pending(), 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
